// File: rtl/apb_reg_completer.sv
// APB completer with a byte-strobed register bank and a read-only transfer counter in the last word.
// Optional slave-error response is enabled by defining APB_SLVERR_EN.
module apb_reg_completer #(
  parameter int ADDR_WD  = 32,
  parameter int DATA_WD  = 32,
  parameter int STRB_WD  = 4,
  parameter int PROT_WD  = 3,
  parameter int REG_NUM  = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic               b_pclk,
  input  logic               b_prst,
  input  logic               b_psel,
  input  logic               b_penable,
  input  logic               b_pwrite,
  input  logic [ADDR_WD-1:0] b_paddr,
  input  logic [DATA_WD-1:0] b_pwdata,
  input  logic [PROT_WD-1:0] b_pprot,
  input  logic [STRB_WD-1:0] b_pstrb,
  output logic [DATA_WD-1:0] b_prdata,
  output logic               b_pready
`ifdef APB_SLVERR_EN
  ,
  output logic               b_pslverr
`endif
);

  localparam int OFF_WD = $clog2(STRB_WD);
  localparam int IDX_WD = $clog2(REG_NUM);
  localparam logic [ADDR_WD-1:0] LIMIT    = ADDR_WD'(REG_NUM * STRB_WD);
  localparam logic [IDX_WD-1:0]  LAST_IDX = IDX_WD'(REG_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           wait_cnt;
  logic                 wr_q;
  logic                 rng_q;
  logic [IDX_WD-1:0]    idx_q;
  logic [DATA_WD-1:0]   wdata_q;
  logic [STRB_WD-1:0]   strb_q;
  logic [DATA_WD-1:0]   regs [REG_NUM-1];
  logic [DATA_WD-1:0]   count;

  logic                 setup;
  logic                 rng_in;
  logic [IDX_WD-1:0]    idx_in;
  logic                 unused_inputs;

  assign setup         = b_psel & ~b_penable;
  assign idx_in        = b_paddr[OFF_WD +: IDX_WD];
  assign rng_in        = (b_paddr < LIMIT);
  assign unused_inputs = ^b_pprot;

  // The counter word reads its pre-increment value; out-of-range reads return zero.
  function automatic logic [DATA_WD-1:0] rd_value(input logic rng, input logic [IDX_WD-1:0] idx);
    if (!rng) begin
      return '0;
    end else if (idx == LAST_IDX) begin
      return count;
    end else begin
      return regs[idx];
    end
  endfunction

`ifdef APB_SLVERR_EN
  function automatic logic slv_err(input logic rng, input logic wr, input logic [IDX_WD-1:0] idx);
    return !rng || (wr && (idx == LAST_IDX));
  endfunction
`endif

  always_ff @(posedge b_pclk) begin
    if (b_prst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      wr_q     <= 1'b0;
      rng_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      count    <= '0;
      b_prdata <= '0;
      b_pready <= 1'b0;
`ifdef APB_SLVERR_EN
      b_pslverr <= 1'b0;
`endif
      for (int i = 0; i < REG_NUM - 1; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (setup) begin
            wr_q    <= b_pwrite;
            rng_q   <= rng_in;
            idx_q   <= idx_in;
            wdata_q <= b_pwdata;
            strb_q  <= b_pstrb;
            if (WAIT_CYC == 0) begin
              state    <= S_DONE;
              b_pready <= 1'b1;
              b_prdata <= rd_value(rng_in, idx_in);
`ifdef APB_SLVERR_EN
              b_pslverr <= slv_err(rng_in, b_pwrite, idx_in);
`endif
            end else begin
              wait_cnt <= 4'(WAIT_CYC);
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Deselect during the wait phase abandons the transfer with no side effects.
          if (!b_psel) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
          end else if (wait_cnt == 4'd1) begin
            state    <= S_DONE;
            wait_cnt <= 4'd0;
            b_pready <= 1'b1;
            b_prdata <= rd_value(rng_q, idx_q);
`ifdef APB_SLVERR_EN
            b_pslverr <= slv_err(rng_q, wr_q, idx_q);
`endif
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          b_pready <= 1'b0;
          b_prdata <= '0;
`ifdef APB_SLVERR_EN
          b_pslverr <= 1'b0;
`endif
          if (b_psel && b_penable) begin
            count <= count + {{(DATA_WD-1){1'b0}}, 1'b1};
            if (wr_q && rng_q && (idx_q != LAST_IDX)) begin
              for (int i = 0; i < STRB_WD; i++) begin
                if (strb_q[i]) begin
                  regs[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
                end
              end
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= 4'd0;
          b_pready <= 1'b0;
          b_prdata <= '0;
`ifdef APB_SLVERR_EN
          b_pslverr <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule
